// File: rtl/tx_event_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_event_arbiter_if
// Description : Signal bundle for tx_event_arbiter. It carries the AXI-Stream
//               monitor taps, the shared four-phase event handshake and the
//               error/status outputs.
//               master : the arbiter side (drives ev_req/ev_id and status)
//               slave  : the environment side (drives taps, ev_ack, err_clr)
//               Ports:
//                 s_tvalid/s_tready/s_tlast [NUM_CH] - monitored stream taps
//                 ev_req, ev_id[ID_W], ev_ack        - four-phase event handshake
//                 pending[NUM_CH]                    - queued event per channel
//                 drop_cnt[CNT_W], drop_mask[NUM_CH] - dropped event status
//                 timeout_err, err_clr               - sticky timeout and clear
//               NUM_CH/ID_W/CNT_W must match the arbiter instance.
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_event_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0] s_tvalid;
  logic [NUM_CH-1:0] s_tready;
  logic [NUM_CH-1:0] s_tlast;
  logic              ev_req;
  logic [ID_W-1:0]   ev_id;
  logic              ev_ack;
  logic [NUM_CH-1:0] pending;
  logic [CNT_W-1:0]  drop_cnt;
  logic [NUM_CH-1:0] drop_mask;
  logic              timeout_err;
  logic              err_clr;

  modport master (
    input  s_tvalid, s_tready, s_tlast, ev_ack, err_clr,
    output ev_req, ev_id, pending, drop_cnt, drop_mask, timeout_err
  );

  modport slave (
    output s_tvalid, s_tready, s_tlast, ev_ack, err_clr,
    input  ev_req, ev_id, pending, drop_cnt, drop_mask, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/tx_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tx_event_arbiter
// Description : Detects the first beat of every packet on NUM_CH monitored
//               AXI-Stream channels, queues one event per channel and reports
//               events round-robin over a single four-phase req/ack handshake
//               to a consumer in another clock domain. Keeps sticky status for
//               dropped events and for handshakes that time out.
//               Ports:
//                 clk  - sole clock
//                 rst  - synchronous, active-high reset
//                 bus  - tx_event_arbiter_if master modport (taps, handshake,
//                        pending flags, drop/timeout status, err_clr)
//               Parameters: NUM_CH (2..16), ID_W (>= clog2(NUM_CH)),
//               ACK_SYNC_STAGES (>= 2), TIMEOUT (0 disables), CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_event_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int ID_W            = 2,
  parameter int ACK_SYNC_STAGES = 2,
  parameter int TIMEOUT         = 1024,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  tx_event_arbiter_if.master  bus
);

  // Timeout counter only needs to reach TIMEOUT-1.
  localparam int              TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ID_W-1:0] C_RR_INIT = ID_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t                     r_state;
  logic [NUM_CH-1:0]          r_in_pkt;
  logic [NUM_CH-1:0]          r_pending;
  logic [NUM_CH-1:0]          r_drop_mask;
  logic [CNT_W-1:0]           r_drop_cnt;
  logic [ACK_SYNC_STAGES-1:0] r_ack_sync;
  logic [ID_W-1:0]            r_rr_ptr;
  logic [ID_W-1:0]            r_ev_id;
  logic                       r_ev_req;
  logic [TO_W-1:0]            r_to_cnt;
  logic                       r_timeout_err;

  logic [NUM_CH-1:0]          w_beat;
  logic [NUM_CH-1:0]          w_sop;
  logic [NUM_CH-1:0]          w_pick;
  logic [NUM_CH-1:0]          w_grant;
  logic [NUM_CH-1:0]          w_drop;
  logic [ID_W-1:0]            w_sel;
  logic                       w_found;
  logic                       w_grant_en;
  logic                       w_ack_s;
  logic                       w_to_hit;

  assign w_beat  = bus.s_tvalid & bus.s_tready;
  assign w_sop   = w_beat & ~r_in_pkt;
  assign w_ack_s = r_ack_sync[ACK_SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // ev_ack comes from another clock domain; only the last stage is used.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[ACK_SYNC_STAGES-2:0], bus.ev_ack};
    end
  end

  // --------------------------------------------------------------------------
  // Packet tracking: a beat without tlast opens a packet, a beat with tlast
  // closes it, so a single-beat packet leaves in_pkt at 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_pkt <= '0;
    end else begin
      r_in_pkt <= (r_in_pkt & ~w_beat) | (w_beat & ~bus.s_tlast);
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin search starting after rr_ptr. The first pass covers channels
  // above the pointer, the second pass wraps to channels at or below it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    w_pick  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && r_pending[i] && (i > int'(r_rr_ptr))) begin
        w_found   = 1'b1;
        w_sel     = ID_W'(i);
        w_pick[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && r_pending[i] && (i <= int'(r_rr_ptr))) begin
        w_found   = 1'b1;
        w_sel     = ID_W'(i);
        w_pick[i] = 1'b1;
      end
    end
  end

  // A stale ack (still high from a previous handshake) blocks new grants.
  assign w_grant_en = (r_state == ST_IDLE) && w_found && !w_ack_s;
  assign w_grant    = w_grant_en ? w_pick : '0;

  // A sop on the channel being granted this cycle refills its slot instead
  // of counting as a drop.
  assign w_drop     = w_sop & r_pending & ~w_grant;
  assign w_to_hit   = (TIMEOUT != 0) && (r_to_cnt == C_TO_LAST);

  // --------------------------------------------------------------------------
  // Pending slots and drop status.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_drop_cnt  <= '0;
      r_drop_mask <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | w_sop;
      if (bus.err_clr) begin
        // Drops coinciding with the clear survive it.
        r_drop_cnt  <= (|w_drop) ? CNT_W'(1) : '0;
        r_drop_mask <= w_drop;
      end else if (|w_drop) begin
        // At most one increment per cycle, however many channels drop.
        if (r_drop_cnt != C_CNT_MAX) begin
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
        r_drop_mask <= r_drop_mask | w_drop;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake FSM with registered ev_req / ev_id.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ev_req      <= 1'b0;
      r_ev_id       <= '0;
      r_rr_ptr      <= C_RR_INIT;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        r_timeout_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_grant_en) begin
            r_ev_id  <= w_sel;
            r_rr_ptr <= w_sel;
            r_ev_req <= 1'b1;
            r_to_cnt <= '0;
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_ack_s) begin
            r_ev_req <= 1'b0;
            r_state  <= ST_REL;
          end else if (w_to_hit) begin
            // The event is treated as consumed; there is no retry.
            r_ev_req      <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= ST_REL;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_REL: begin
          if (!w_ack_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ev_req <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ev_req      = r_ev_req;
  assign bus.ev_id       = r_ev_id;
  assign bus.pending     = r_pending;
  assign bus.drop_cnt    = r_drop_cnt;
  assign bus.drop_mask   = r_drop_mask;
  assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_tx_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_event_arbiter
// Description : Directed bench for tx_event_arbiter. dut0 uses TIMEOUT=16 and
//               a 16-bit drop counter; dut1 shares the same stimulus with the
//               timeout disabled and a 2-bit drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_event_arbiter;

  logic clk;
  logic rst;

  tx_event_arbiter_if #(.NUM_CH(4), .ID_W(2), .CNT_W(16)) if0 ();
  tx_event_arbiter_if #(.NUM_CH(4), .ID_W(2), .CNT_W(2))  if1 ();

  tx_event_arbiter #(
    .NUM_CH(4), .ID_W(2), .ACK_SYNC_STAGES(2), .TIMEOUT(16), .CNT_W(16)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
  );

  tx_event_arbiter #(
    .NUM_CH(4), .ID_W(2), .ACK_SYNC_STAGES(2), .TIMEOUT(0), .CNT_W(2)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.master)
  );

  assign if1.s_tvalid = if0.s_tvalid;
  assign if1.s_tready = if0.s_tready;
  assign if1.s_tlast  = if0.s_tlast;
  assign if1.ev_ack   = if0.ev_ack;
  assign if1.err_clr  = if0.err_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] tv;
    logic [3:0] tr;
    logic [3:0] tl;
    logic       ack;
    logic       req;
    logic [1:0] id;
    logic [3:0] pend;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [3:0] tv, input logic [3:0] tr,
                              input logic [3:0] tl, input logic ack,
                              input logic req, input logic [1:0] id,
                              input logic [3:0] pend);
    vec_t v;
    v.tv = tv; v.tr = tr; v.tl = tl; v.ack = ack;
    v.req = req; v.id = id; v.pend = pend;
    vq.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] tv, input logic [3:0] tr, input logic [3:0] tl);
    if0.s_tvalid = tv;
    if0.s_tready = tr;
    if0.s_tlast  = tl;
  endtask

  // One-cycle single-beat packet on every channel in mask.
  task automatic sop(input logic [3:0] m);
    drive(m, m, m);
    tick();
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic do_reset();
    drive(4'b0000, 4'b0000, 4'b0000);
    if0.ev_ack  = 1'b0;
    if0.err_clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Counts cycles until dut0 raises ev_req; an expired budget shows as a
  // count mismatch.
  task automatic wait_req(input string nm, input int exp_n);
    int n;
    n = 0;
    while (!if0.ev_req && n < 30) begin
      tick();
      n++;
    end
    chk(nm, n, exp_n);
  endtask

  // Consumer side of one four-phase handshake on dut0, entered with ev_req=1.
  task automatic hs(input string nm, input int exp_id);
    int n;
    chk({nm, "_id"}, int'(if0.ev_id), exp_id);
    tick();
    tick();
    if0.ev_ack = 1'b1;
    n = 0;
    while (if0.ev_req && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_ack_to_fall"}, n, 3);
    if0.ev_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    do_reset();

    // ---------------- reset values ----------------
    chk("rst_req0",   int'(if0.ev_req),      0);
    chk("rst_id0",    int'(if0.ev_id),       0);
    chk("rst_pend0",  int'(if0.pending),     0);
    chk("rst_cnt0",   int'(if0.drop_cnt),    0);
    chk("rst_mask0",  int'(if0.drop_mask),   0);
    chk("rst_tmo0",   int'(if0.timeout_err), 0);
    chk("rst_req1",   int'(if1.ev_req),      0);
    chk("rst_cnt1",   int'(if1.drop_cnt),    0);

    // ---------------- table: single event, multi-beat packets ----------------
    add(4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000); // valid without ready
    add(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100); // ch2 single beat
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000); // grant ch2
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000); // ack rises
    add(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000); // req falls
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000); // ack falls
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000); // back in idle
    add(4'b0010, 4'b1010, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0010); // ch1 first beat; ch3 ready only
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000); // grant ch1
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000);
    add(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000); // beat 2
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000);
    add(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000); // beat 3
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000);
    add(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0000); // beat 4, tlast
    add(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010); // second packet
    add(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010);
    add(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010);
    add(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0010);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0010);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0010);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0010); // idle
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000); // grant ch1 again
    add(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000); // no third event

    foreach (vq[k]) begin
      drive(vq[k].tv, vq[k].tr, vq[k].tl);
      if0.ev_ack = vq[k].ack;
      tick();
      chk($sformatf("vec%0d_req", k),  int'(if0.ev_req),  int'(vq[k].req));
      chk($sformatf("vec%0d_id", k),   int'(if0.ev_id),   int'(vq[k].id));
      chk($sformatf("vec%0d_pend", k), int'(if0.pending), int'(vq[k].pend));
    end
    drive(4'b0000, 4'b0000, 4'b0000);
    if0.ev_ack = 1'b0;
    chk("vec_drop_cnt", int'(if0.drop_cnt),    0);
    chk("vec_timeout",  int'(if0.timeout_err), 0);

    // ---------------- round-robin fairness ----------------
    do_reset();
    sop(4'b1111);
    chk("rr_pend_all", int'(if0.pending), 'b1111);
    wait_req("rr_lat0", 1);
    hs("rr_g0", 0);
    wait_req("rr_lat1", 4);
    hs("rr_g1", 1);
    wait_req("rr_lat2", 4);
    hs("rr_g2", 2);
    wait_req("rr_lat3", 4);
    sop(4'b1001);
    chk("rr_repend", int'(if0.pending), 'b1001);
    hs("rr_g3", 3);
    wait_req("rr_lat4", 4);
    hs("rr_g4", 0);
    wait_req("rr_lat5", 4);
    hs("rr_g5", 3);
    repeat (6) tick();
    chk("rr_pend_end", int'(if0.pending),  0);
    chk("rr_req_end",  int'(if0.ev_req),   0);
    chk("rr_drops",    int'(if0.drop_cnt), 0);

    // ---------------- timeout ----------------
    do_reset();
    sop(4'b0110);
    wait_req("to_lat", 1);
    chk("to_id", int'(if0.ev_id), 1);
    begin
      int n;
      n = 0;
      while (if0.ev_req && n < 40) begin
        tick();
        n++;
      end
      chk("to_high_cycles", n, 16);
    end
    chk("to_err_set", int'(if0.timeout_err), 1);
    wait_req("to_next_lat", 2);
    hs("to_next", 2);
    chk("to_err_sticky", int'(if0.timeout_err), 1);
    if0.err_clr = 1'b1;
    tick();
    if0.err_clr = 1'b0;
    chk("to_err_clr", int'(if0.timeout_err), 0);

    // ---------------- drop path (dut1: no timeout, 2-bit counter) ----------------
    do_reset();
    sop(4'b0001);
    tick();
    chk("dr_req", int'(if1.ev_req), 1);
    drive(4'b0010, 4'b0010, 4'b0010);
    repeat (3) tick();
    drive(4'b0000, 4'b0000, 4'b0000);
    chk("dr_cnt2",  int'(if1.drop_cnt),  2);
    chk("dr_mask",  int'(if1.drop_mask), 'b0010);
    chk("dr_pend",  int'(if1.pending),   'b0010);
    repeat (20) tick();
    chk("dr_req_held",  int'(if1.ev_req),      1);
    chk("dr_no_tmo",    int'(if1.timeout_err), 0);
    if0.err_clr = 1'b1;
    sop(4'b0010);
    if0.err_clr = 1'b0;
    chk("dr_clr_cnt",  int'(if1.drop_cnt),  1);
    chk("dr_clr_mask", int'(if1.drop_mask), 'b0010);
    sop(4'b0101);
    chk("dr_pend3", int'(if1.pending),  'b0111);
    chk("dr_cnt_a", int'(if1.drop_cnt), 1);
    sop(4'b0101);
    chk("dr_multi_cnt",  int'(if1.drop_cnt),  2);
    chk("dr_multi_mask", int'(if1.drop_mask), 'b0111);
    sop(4'b0010);
    chk("dr_cnt_max", int'(if1.drop_cnt), 3);
    sop(4'b0010);
    chk("dr_cnt_sat", int'(if1.drop_cnt), 3);

    // ---------------- reset mid-handshake with stale ack ----------------
    do_reset();
    sop(4'b0011);
    wait_req("sr_lat", 1);
    chk("sr_id0", int'(if0.ev_id), 0);
    if0.ev_ack = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sr_req_rst",  int'(if0.ev_req),  0);
    chk("sr_pend_rst", int'(if0.pending), 0);
    tick();
    tick();
    sop(4'b0100);
    chk("sr_pend2", int'(if0.pending), 'b0100);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sr_stale_hold%0d", k), int'(if0.ev_req), 0);
      tick();
    end
    if0.ev_ack = 1'b0;
    wait_req("sr_release_lat", 3);
    hs("sr_hs", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
